// File: rtl/gray_conv_pkg.sv
// Shared types and constants for the shared Gray/binary converter arbiter.
package gray_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

endpackage

// File: rtl/gray_conv_arbiter_codec.sv
// Combinational binary<->Gray converter; one instance is shared by all requesters.
module gray_codec
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] bin;

  always_comb begin
    bin            = '0;
    bin[WIDTH-1]   = din[WIDTH-1];
    for (int unsigned k = 1; k < WIDTH; k++) begin
      bin[WIDTH-1-k] = bin[WIDTH-k] ^ din[WIDTH-1-k];
    end

    dout = '0;
    unique case (mode)
      MODE_B2G: dout = din ^ (din >> 1);
      MODE_G2B: dout = bin;
    endcase
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters through one registered Gray/binary converter.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_mode,
  input  logic                  rsp_ready
);

  state_e           state_q,     state_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [WIDTH-1:0] op_data_q,   op_data_d;
  logic             op_mode_q,   op_mode_d;
  logic [IDW-1:0]   op_id_q,     op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic             rsp_mode_q,  rsp_mode_d;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] win_data;
  logic             win_mode;
  logic [WIDTH-1:0] conv_out;

  // First valid requester at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    win_data  = '0;
    win_mode  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
        win_data  = WIDTH'(req_data >> (32'(cand) * WIDTH));
        win_mode  = req_mode[cand];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && win_found && !rst) begin
      req_ready[win_id] = 1'b1;
    end
  end

  gray_codec #(
    .WIDTH(WIDTH)
  ) u_codec (
    .mode (op_mode_q),
    .din  (op_data_q),
    .dout (conv_out)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_data_d   = op_data_q;
    op_mode_d   = op_mode_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_mode_d  = rsp_mode_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          op_data_d = win_data;
          op_mode_d = win_mode;
          op_id_d   = win_id;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        rsp_data_d  = conv_out;
        rsp_mode_d  = op_mode_q;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Pointer moves only on completion, so the owner cannot win back-to-back.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_data_q   <= '0;
      op_mode_q   <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_data_q   <= op_data_d;
      op_mode_q   <= op_mode_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_mode_q  <= rsp_mode_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_mode  = rsp_mode_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench: a grant predictor pushes expected responses, a monitor pops and compares.
module tb_gray_conv_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);
  localparam int MAXQ  = 64;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_mode  = '0;
  logic [NREQ*WIDTH-1:0] req_data  = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_mode;
  logic                  rsp_ready = 1'b0;

  gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_mode(rsp_mode),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; bit mode; int unsigned data; int acc; } exp_t;
  typedef struct { int id; int unsigned data; int cyc; } log_t;
  exp_t exp_q[$];
  log_t log_q[$];
  int   m_ptr       = 0;
  int   release_cyc = 0;
  logic [NREQ-1:0] hs_mask = '0;
  logic [NREQ-1:0] last_hs = '0;

  int unsigned src_data [NREQ][MAXQ];
  bit          src_mode [NREQ][MAXQ];
  int          src_cnt  [NREQ];
  int          src_rd   [NREQ];
  int          rr_mode = 1;
  bit          gap_en  = 1'b0;
  bit          drop_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion: Gray->binary is the XOR of all right shifts of the word.
  function automatic int unsigned model_conv(input bit mode, input int unsigned d);
    int unsigned r;
    if (!mode) return d ^ (d >> 1);
    r = 0;
    for (int unsigned s = d; s != 0; s = s >> 1) r ^= s;
    return r;
  endfunction

  // Grant predictor
  always @(negedge clk) begin : predictor
    int win;
    logic [NREQ-1:0] onehot;
    exp_t e;
    hs_mask = req_ready & req_valid;
    if (rst) begin
      chk("ready_in_reset", req_ready, 0);
    end else if (cyc < release_cyc) begin
      chk("ready_while_busy", req_ready, 0);
    end else begin
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
      if (win < 0) begin
        chk("ready_no_request", req_ready, 0);
      end else begin
        onehot = '0;
        onehot[win] = 1'b1;
        chk("grant", req_ready, onehot);
        e.id   = win;
        e.mode = req_mode[win];
        e.data = model_conv(req_mode[win], req_data[win*WIDTH +: WIDTH]);
        e.acc  = cyc;
        exp_q.push_back(e);
        release_cyc = 32'h7fffffff;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin : monitor
    bit   expv;
    log_t l;
    if (!rst) begin
      expv = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
      chk("rsp_valid", rsp_valid, expv);
      if (rsp_valid && expv) begin
        chk("rsp_data", rsp_data, exp_q[0].data);
        chk("rsp_id",   rsp_id,   exp_q[0].id);
        chk("rsp_mode", rsp_mode, exp_q[0].mode);
        if (rsp_ready) begin
          l.id = exp_q[0].id; l.data = exp_q[0].data; l.cyc = cyc;
          log_q.push_back(l);
          m_ptr       = (exp_q[0].id + 1) % NREQ;
          release_cyc = cyc + 1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    bit dropped;
    @(posedge clk); #1;
    last_hs = hs_mask;
    for (int i = 0; i < NREQ; i++) begin
      dropped = 1'b0;
      if (hs_mask[i]) req_valid[i] = 1'b0;
      else if (drop_en && req_valid[i] && $urandom_range(0, 19) == 0) begin
        req_valid[i] = 1'b0;
        dropped = 1'b1;
      end
      if (!dropped && !req_valid[i] && src_rd[i] < src_cnt[i] &&
          (!gap_en || $urandom_range(0, 3) != 0)) begin
        req_data[i*WIDTH +: WIDTH] = WIDTH'(src_data[i][src_rd[i]]);
        req_mode[i]  = src_mode[i][src_rd[i]];
        req_valid[i] = 1'b1;
        src_rd[i]++;
      end
    end
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic add_item(input int i, input bit mode, input int unsigned data);
    src_data[i][src_cnt[i]] = data;
    src_mode[i][src_cnt[i]] = mode;
    src_cnt[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NREQ; i++) begin src_cnt[i] = 0; src_rd[i] = 0; end
  endtask

  function automatic bit all_fed();
    for (int i = 0; i < NREQ; i++) if (src_rd[i] != src_cnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc && !(all_fed() && req_valid == '0 && exp_q.size() == 0 && !rsp_valid)) begin
      step();
      n++;
    end
    chk({name, "_drain_timeout"}, n >= max_cyc, 0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    m_ptr       = 0;
    release_cyc = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    flush_model();
    step();
    step();
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] bin_vec  [5] = '{4'b1011, 4'b0111, 4'b0101, 4'b1100, 4'b1111};
  logic [WIDTH-1:0] gray_vec [5] = '{4'b1110, 4'b0100, 4'b0111, 4'b1010, 4'b1000};
  int rr_ids [6] = '{0, 1, 2, 3, 0, 1};
  int sp_ids [4] = '{3, 1, 3, 1};

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int n;
    int rise_cyc;
    clear_src();
    rr_mode = 1;

    reset_dut();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data",  rsp_data,  0);
    chk("reset_rsp_id",    rsp_id,    0);
    chk("reset_rsp_mode",  rsp_mode,  0);
    chk("reset_req_ready", req_ready, 0);

    // Single requester, binary->Gray
    clear_src(); log_q.delete();
    for (int k = 0; k < 5; k++) add_item(0, 1'b0, bin_vec[k]);
    drain("b2g", 100);
    chk("b2g_count", log_q.size(), 5);
    for (int k = 0; k < 5 && k < log_q.size(); k++) begin
      chk("b2g_const_data", log_q[k].data, gray_vec[k]);
      chk("b2g_const_id",   log_q[k].id,   0);
    end

    // Single requester, Gray->binary
    clear_src(); log_q.delete();
    for (int k = 0; k < 5; k++) add_item(0, 1'b1, gray_vec[k]);
    drain("g2b", 100);
    chk("g2b_count", log_q.size(), 5);
    for (int k = 0; k < 5 && k < log_q.size(); k++)
      chk("g2b_const_data", log_q[k].data, bin_vec[k]);

    // All four requesters contending
    reset_dut();
    clear_src(); log_q.delete();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 2; k++) add_item(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    drain("rr", 200);
    chk("rr_count", log_q.size(), 8);
    for (int k = 0; k < 6 && k < log_q.size(); k++) chk("rr_order", log_q[k].id, rr_ids[k]);
    for (int k = 1; k < log_q.size(); k++) chk("rr_spacing", log_q[k].cyc - log_q[k-1].cyc, 3);

    // Backpressure on the response channel
    clear_src(); log_q.delete();
    rr_mode = 0;
    add_item(1, 1'b0, 4'b0110);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("bp_rsp_seen", rsp_valid, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_ready", req_ready, 0);
    end
    rr_mode   = 1;
    rsp_ready = 1'b1;
    rise_cyc  = cyc;
    drain("bp", 50);
    chk("bp_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk("bp_complete_cycle", log_q[0].cyc, rise_cyc);
      chk("bp_const_data", log_q[0].data, 4'b0101);
    end

    // Reset while a transaction sits in CONV
    clear_src(); log_q.delete();
    add_item(2, 1'b0, 4'b1001);
    n = 0;
    last_hs = '0;
    while (!last_hs[2] && n < 10) begin step(); n++; end
    chk("rst_conv_accept", last_hs[2], 1);
    rst = 1'b1;
    flush_model();
    step();
    rst = 1'b0;
    chk("rst_conv_rsp_valid", rsp_valid, 0);
    chk("rst_conv_rsp_data",  rsp_data,  0);
    chk("rst_conv_rsp_id",    rsp_id,    0);
    add_item(0, 1'b1, 4'b0011);
    add_item(2, 1'b0, 4'b1001);
    drain("rst_conv", 50);
    chk("rst_conv_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("rst_conv_first_id",  log_q[0].id, 0);
      chk("rst_conv_second_id", log_q[1].id, 2);
    end

    // Sparse requesters across the wrap point, starting from pointer 2
    clear_src();
    add_item(1, 1'b0, 4'b0001);
    drain("sparse_setup", 50);
    clear_src(); log_q.delete();
    for (int k = 0; k < 2; k++) begin
      add_item(3, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      add_item(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    end
    drain("sparse", 100);
    chk("sparse_count", log_q.size(), 4);
    for (int k = 0; k < 4 && k < log_q.size(); k++) chk("sparse_order", log_q[k].id, sp_ids[k]);

    // Randomised traffic with gaps, early drops and random backpressure
    clear_src(); log_q.delete();
    rr_mode = 2; gap_en = 1'b1; drop_en = 1'b1;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 40; k++) add_item(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    drain("random", 5000);
    gap_en = 1'b0; drop_en = 1'b0; rr_mode = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Shares a single binary/Gray code converter between `NREQ` requesters. Each requester presents a word and a direction (binary→Gray or Gray→binary) over a valid/ready handshake. A round-robin arbiter grants one requester at a time, and the block sequences the word through a registered conversion stage. The tagged result is returned on one response channel with backpressure. The block sits in front of the code-conversion datapath, so that counters, pointers and test logic in the design share one converter.

## Interface
Parameters:
- `WIDTH`, 4: word width in bits; must be ≥ 2.
- `NREQ`, 4: number of requesters; must be ≥ 2.
- `IDW`, `$clog2(NREQ)`: width of the requester ID (local parameter).

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input NREQ: per-requester request valid.
- `req_mode` input NREQ: per-requester direction; 0 = binary→Gray, 1 = Gray→binary.
- `req_data` input NREQ*WIDTH: packed request words; requester i uses bits [i*WIDTH +: WIDTH].
- `req_ready` output NREQ: per-requester accept, one-hot or zero.
- `rsp_valid` output 1: response valid.
- `rsp_data` output WIDTH: converted word.
- `rsp_id` output IDW: index of the requester that owns the response.
- `rsp_mode` output 1: direction used for this response.
- `rsp_ready` input 1: consumer accepts the response.

## Operation
State machine with three states:
- **IDLE**
  - If any `req_valid` bit is set, pick the winner: the first set bit found searching upward from `rr_ptr`, wrapping at NREQ.
  - Drive `req_ready[winner]=1` combinationally in this cycle; that handshake is the accept.
  - Latch the winner's data, mode and ID. Go to CONV.
  - If no request, stay in IDLE with `req_ready=0`.
- **CONV**
  - Compute the conversion from the latched operands and register it into `rsp_data` and `rsp_mode`. Load `rsp_id`.
  - Set `rsp_valid`. Go to RESP.
- **RESP**
  - Hold `rsp_*` stable while `rsp_ready=0`.
  - On `rsp_ready=1`: clear `rsp_valid`, set `rr_ptr = (id+1) mod NREQ`, go to IDLE.

Conversion rules:
- Binary→Gray: `g = b ^ (b >> 1)`.
- Gray→binary: `b[WIDTH-1] = g[WIDTH-1]`, then `b[i] = b[i+1] ^ g[i]` for i descending.
- Purely bitwise; no carry and no width growth.

General rules:
- `req_ready` is 0 in CONV and RESP, and 0 while `rst=1`.
- Requesters must hold valid, data and mode until they see ready.
- A requester that drops valid before its grant is simply skipped; no error is flagged.
- The arbitration pointer advances only on response completion. A requester cannot win twice in a row while another requester is waiting.

## Timing
- Reset values: state=IDLE, `rr_ptr=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `rsp_mode=0`, `req_ready=0`.
- Latency: accept in cycle N (IDLE), `rsp_valid` high from cycle N+2.
- Earliest next accept is cycle N+3 if `rsp_ready=1` at N+2. Peak throughput is one conversion per 3 cycles.
- Simultaneous requests: exactly one `req_ready` bit is high, chosen by the round-robin order.
- Wrap-around: `rr_ptr=NREQ-1` searches NREQ-1, 0, 1, …
- Reset mid-operation (CONV or RESP): the in-flight transaction is discarded with no response. Outputs return to reset values on the next edge.
- `rsp_ready` held high while in IDLE or CONV has no effect.

## Structure
Shared package `gray_conv_pkg` holds:
- State enum: `ST_IDLE`, `ST_CONV`, `ST_RESP`.
- Mode constants: `MODE_B2G=1'b0`, `MODE_G2B=1'b1`.

Sub-module `gray_codec`: combinational, parameterised by `WIDTH`; inputs `mode` and `din`, output `dout`. It implements both directions and is instantiated once. The arbiter and FSM live in the top module.

## Test plan
- Single requester 0, B2G. Inputs 1011, 0111, 0101, 1100, 1111 → responses 1110, 0100, 0111, 1010, 1000, all with `rsp_id=0` and latency 2.
- G2B inverse. Inputs 1110, 0100, 0111, 1010, 1000 → responses 1011, 0111, 0101, 1100, 1111.
- Round-robin. All four requesters valid continuously with `rsp_ready=1` → `rsp_id` sequence 0, 1, 2, 3, 0, 1, one response every 3 cycles.
- Backpressure. `rsp_ready=0` for 5 cycles after `rsp_valid` → `rsp_data` and `rsp_id` stay stable, all `req_ready=0`. The response completes on the cycle `rsp_ready` rises.
- Reset in CONV. Accept requester 2, assert `rst` the next cycle → no response appears, `rr_ptr=0`, and the next grant goes to requester 0 when requesters 0 and 2 are both valid.
- Sparse wrap. Only requesters 3 and 1 valid, starting with `rr_ptr=2` → grant order 3, 1, 3.
